// File: rtl/avalon_wait_ram.sv
// avalon_wait_ram: Avalon-MM slave wrapping a word-addressed RAM with a
// fixed number of wait states, a side-band preload port and a sticky flag
// that records bus protocol violations.
//
// Handshake: a transfer is requested while read or write is high. The slave
// stalls it by holding waitrequest high. The transfer completes in the single
// cycle where the request is high and waitrequest is low. The master must hold
// read/write, address and writedata stable until that completion cycle.
module avalon_wait_ram #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        protocol_error
);

    localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);
    localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        pend_q, pend_d;
    logic [31:0] addr_q, addr_d;

    logic [31:0] bus_idx, load_idx;
    logic        bus_in_range, load_in_range;
    logic        req, complete;
    logic        bus_we, load_we;
    logic [31:0] lane_mask;

    // Address decode, handshake and lane mask.
    always_comb begin
        bus_idx       = (address - BASE_ADDR) >> 2;
        load_idx      = (load_addr - BASE_ADDR) >> 2;
        bus_in_range  = bus_idx < DEPTH;
        load_in_range = load_idx < DEPTH;
        req           = read | write;
        // A preload or an active reset always stalls the bus, so a preload
        // and a bus write can never land in the same cycle.
        waitrequest   = req & ((cnt_q != WS) | load_en | ~reset);
        complete      = req & ~waitrequest;
        bus_we        = complete & write & bus_in_range;
        load_we       = load_en & load_in_range & reset;
        lane_mask     = {{8{byteenable[3]}}, {8{byteenable[2]}},
                         {8{byteenable[1]}}, {8{byteenable[0]}}};
    end

    // Read data is only driven for a pure in-range read.
    always_comb begin
        readdata = 32'h0;
        if (read && !write && bus_in_range) begin
            readdata = mem_q[bus_idx[AW-1:0]];
        end
    end

    // Next-state for the wait counter, the stall tracker and the error flag.
    always_comb begin
        cnt_d  = cnt_q;
        pend_d = req & waitrequest;
        addr_d = address;
        err_d  = err_q;
        if (!req || complete) begin
            cnt_d = 4'd0;
        end else if (!load_en && cnt_q < WS) begin
            cnt_d = cnt_q + 4'd1;
        end
        // Request withdrawn while stalled, address moved while stalled,
        // or read and write asserted together.
        if ((pend_q && !req) || (pend_q && req && address != addr_q) ||
            (read && write)) begin
            err_d = 1'b1;
        end
        if (!reset) begin
            cnt_d  = 4'd0;
            pend_d = 1'b0;
            err_d  = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= 4'd0;
            pend_q <= 1'b0;
            addr_q <= 32'h0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

    // Memory array: cleared by reset, written by preload or bus write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= 32'h0;
            end
        end else begin
            if (load_we) begin
                mem_q[load_idx[AW-1:0]] <= load_data;
            end
            if (bus_we) begin
                mem_q[bus_idx[AW-1:0]] <= (mem_q[bus_idx[AW-1:0]] & ~lane_mask) |
                                          (writedata & lane_mask);
            end
        end
    end

    assign protocol_error = err_q;

endmodule

// File: tb/tb_avalon_wait_ram.sv
// tb_avalon_wait_ram: directed bench for avalon_wait_ram with WAIT_STATES=2,
// DEPTH_WORDS=1024, BASE_ADDR=0. Inputs change on the falling edge and
// outputs are sampled 1 ns after it.
module tb_avalon_wait_ram;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        protocol_error;

    int n_checks = 0;
    int n_errors = 0;

    avalon_wait_ram #(
        .WAIT_STATES(2),
        .DEPTH_WORDS(1024),
        .BASE_ADDR  (32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .protocol_error(protocol_error)
    );

    // Clock and reset block
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Driver: preload one word over one clock edge.
    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Driver: one bus transfer; lat counts stalled cycles before completion.
    task automatic bus_xfer(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be,
                            output int lat, output logic [31:0] rdata);
        @(negedge clk);
        read = rd; write = wr; address = a; writedata = wd; byteenable = be;
        lat = 0;
        #1;
        while (waitrequest && lat < 50) begin
            @(negedge clk); #1;
            lat++;
        end
        rdata = readdata;
        @(negedge clk);
        read = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output int lat, output logic [31:0] rdata);
        bus_xfer(1'b1, 1'b0, a, 32'h0, 4'h0, lat, rdata);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, output int lat);
        logic [31:0] unused_rd;
        bus_xfer(1'b0, 1'b1, a, wd, be, lat, unused_rd);
    endtask

    int          lat;
    logic [31:0] rd;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_wait_idle", 32'(waitrequest), 32'd0);
        check_eq("rst_readdata", readdata, 32'h0);
        check_eq("rst_err", 32'(protocol_error), 32'd0);
        read = 1'b1; address = 32'h4;
        #1;
        check_eq("rst_wait_req", 32'(waitrequest), 32'd1);
        @(negedge clk);
        read = 1'b0;
        reset = 1'b1;

        // Preload and read back with full latency
        preload(32'h04, 32'h24020090);
        preload(32'h08, 32'h00421023);
        bus_read(32'h08, lat, rd);
        check_eq("rd08_lat", 32'(lat), 32'd2);
        check_eq("rd08_data", rd, 32'h00421023);
        bus_read(32'h04, lat, rd);
        check_eq("rd04_data", rd, 32'h24020090);
        check_eq("err_clean", 32'(protocol_error), 32'd0);

        // Byte-lane writes
        bus_write(32'h10, 32'hAABBCCDD, 4'hF, lat);
        check_eq("wr10_lat", 32'(lat), 32'd2);
        bus_write(32'h10, 32'h11223344, 4'b0101, lat);
        bus_read(32'h10, lat, rd);
        check_eq("rd10_lanes", rd, 32'hAA22CC44);
        bus_write(32'h10, 32'hFFFFFFFF, 4'h0, lat);
        check_eq("wr10_be0_lat", 32'(lat), 32'd2);
        bus_read(32'h10, lat, rd);
        check_eq("rd10_be0", rd, 32'hAA22CC44);
        bus_read(32'h13, lat, rd);
        check_eq("rd13_lowbits", rd, 32'hAA22CC44);

        // Out-of-range (index 1024) and the word it would alias onto
        bus_read(32'h1000, lat, rd);
        check_eq("oor_rd_lat", 32'(lat), 32'd2);
        check_eq("oor_rd_data", rd, 32'h0);
        bus_write(32'h1000, 32'hDEADBEEF, 4'hF, lat);
        check_eq("oor_wr_lat", 32'(lat), 32'd2);
        bus_read(32'h0, lat, rd);
        check_eq("oor_alias0", rd, 32'h0);
        bus_read(32'h10, lat, rd);
        check_eq("oor_keep10", rd, 32'hAA22CC44);
        check_eq("oor_err", 32'(protocol_error), 32'd0);

        // Request dropped after one wait cycle
        @(negedge clk);
        read = 1'b1; address = 32'h08;
        @(negedge clk);
        read = 1'b0;
        @(negedge clk); #1;
        check_eq("drop_err", 32'(protocol_error), 32'd1);
        bus_read(32'h08, lat, rd);
        check_eq("after_drop_lat", 32'(lat), 32'd2);
        check_eq("after_drop_data", rd, 32'h00421023);
        check_eq("drop_err_sticky", 32'(protocol_error), 32'd1);

        // Preload held for 3 cycles during a pending read
        @(negedge clk);
        read = 1'b1; address = 32'h08; lat = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            load_en = 1'b1; load_addr = 32'h100; load_data = 32'h5A5A0000 + 32'(i);
            lat++;
            #1;
            check_eq("load_stall_wait", 32'(waitrequest), 32'd1);
        end
        @(negedge clk);
        load_en = 1'b0;
        lat++;
        #1;
        while (waitrequest && lat < 50) begin
            @(negedge clk); #1;
            lat++;
        end
        check_eq("load_stall_lat", 32'(lat), 32'd5);
        check_eq("load_stall_data", readdata, 32'h00421023);
        @(negedge clk);
        read = 1'b0;
        bus_read(32'h100, lat, rd);
        check_eq("load_word", rd, 32'h5A5A0002);

        // Reset during a write wait, request withdrawn at release
        @(negedge clk);
        write = 1'b1; address = 32'h20; writedata = 32'h77777777; byteenable = 4'hF;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_mid_wait", 32'(waitrequest), 32'd1);
        @(negedge clk);
        reset = 1'b1; write = 1'b0;
        bus_read(32'h20, lat, rd);
        check_eq("rst_abort_word", rd, 32'h0);
        check_eq("rst_clears_err", 32'(protocol_error), 32'd0);
        bus_read(32'h08, lat, rd);
        check_eq("rst_clears_mem", rd, 32'h0);

        // Reset during a write wait, request held through release
        @(negedge clk);
        write = 1'b1; address = 32'h20; writedata = 32'hCAFEF00D; byteenable = 4'hF;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; lat = 0;
        #1;
        while (waitrequest && lat < 50) begin
            @(negedge clk); #1;
            lat++;
        end
        check_eq("retry_lat", 32'(lat), 32'd2);
        @(negedge clk);
        write = 1'b0;
        bus_read(32'h20, lat, rd);
        check_eq("retry_word", rd, 32'hCAFEF00D);
        check_eq("retry_err", 32'(protocol_error), 32'd0);

        // Address moved while stalled: the completion-cycle address wins
        preload(32'h04, 32'h11111111);
        preload(32'h08, 32'h22222222);
        @(negedge clk);
        read = 1'b1; address = 32'h04; lat = 0;
        @(negedge clk);
        address = 32'h08; lat++;
        #1;
        while (waitrequest && lat < 50) begin
            @(negedge clk); #1;
            lat++;
        end
        check_eq("addr_chg_lat", 32'(lat), 32'd2);
        check_eq("addr_chg_data", readdata, 32'h22222222);
        @(negedge clk);
        read = 1'b0;
        #1;
        check_eq("addr_chg_err", 32'(protocol_error), 32'd1);

        // Read and write together: treated as a write, readdata zero
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        preload(32'h30, 32'h99999999);
        @(negedge clk);
        read = 1'b1; write = 1'b1; address = 32'h30; writedata = 32'h00001234; byteenable = 4'hF;
        lat = 0;
        #1;
        check_eq("rw_rdata_wait", readdata, 32'h0);
        while (waitrequest && lat < 50) begin
            @(negedge clk); #1;
            lat++;
        end
        check_eq("rw_lat", 32'(lat), 32'd2);
        check_eq("rw_rdata_done", readdata, 32'h0);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        #1;
        check_eq("rw_err", 32'(protocol_error), 32'd1);
        bus_read(32'h30, lat, rd);
        check_eq("rw_written", rd, 32'h00001234);

        // Final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
